// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with registered result/NZCV flags and valid/ready
// handshakes on both sides. Non-MUL ops complete at the acceptance edge.
// MUL runs a radix-2 shift-add over WIDTH further cycles.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [2:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic [3:0]       ALUFlag
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LSL = 3'b101;
    localparam logic [2:0] OP_LSR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] mcand_reg, mplier_reg, acc_reg;
    logic [SHW-1:0]   count_reg;
    logic [WIDTH-1:0] result_reg;
    logic [3:0]       flag_reg;

    logic accept, load_op, load_mul, mul_step, mul_last;

    // Single-cycle datapath for every op except MUL.
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   add_ext, sub_ext, lsl_ext, lsr_ext;
    logic [WIDTH-1:0] alu_r;
    logic             alu_c, alu_v;

    assign shamt   = SrcB[SHW-1:0];
    assign add_ext = {1'b0, SrcA} + {1'b0, SrcB};
    assign sub_ext = {1'b0, SrcA} + {1'b0, ~SrcB} + {{WIDTH{1'b0}}, 1'b1};
    // The extra bit catches the last bit shifted out; it stays 0 for shamt=0.
    assign lsl_ext = {1'b0, SrcA} << shamt;
    assign lsr_ext = {SrcA, 1'b0} >> shamt;

    // Result, carry and overflow for the single-cycle ops.
    always_comb begin
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (ALUControl)
            OP_ADD: begin
                alu_r = add_ext[WIDTH-1:0];
                alu_c = add_ext[WIDTH];
                alu_v = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (alu_r[WIDTH-1] != SrcA[WIDTH-1]);
            end
            OP_SUB: begin
                alu_r = sub_ext[WIDTH-1:0];
                alu_c = sub_ext[WIDTH];
                alu_v = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (alu_r[WIDTH-1] != SrcA[WIDTH-1]);
            end
            OP_AND: alu_r = SrcA & SrcB;
            OP_OR:  alu_r = SrcA | SrcB;
            OP_XOR: alu_r = SrcA ^ SrcB;
            OP_LSL: begin
                alu_r = lsl_ext[WIDTH-1:0];
                alu_c = lsl_ext[WIDTH];
            end
            OP_LSR: begin
                alu_r = lsr_ext[WIDTH:1];
                alu_c = lsr_ext[0];
            end
            default: alu_r = '0;
        endcase
    end

    // One shift-add step: add the multiplicand when the current multiplier bit is set.
    logic [WIDTH-1:0] mul_sum;
    assign mul_sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic and handshake outputs; in_ready depends only on state.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        load_op    = 1'b0;
        load_mul   = 1'b0;
        mul_step   = 1'b0;
        mul_last   = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (accept) begin
                    if (ALUControl == OP_MUL) begin
                        load_mul   = 1'b1;
                        state_next = BUSY;
                    end else begin
                        load_op    = 1'b1;
                        state_next = HOLD;
                    end
                end
            end
            BUSY: begin
                mul_step = 1'b1;
                if (count_reg == SHW'(WIDTH - 1)) begin
                    mul_last   = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, multiplier iteration and result/flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            count_reg  <= '0;
            result_reg <= '0;
            flag_reg   <= '0;
        end else begin
            if (load_op) begin
                result_reg <= alu_r;
                flag_reg   <= {alu_r[WIDTH-1], (alu_r == '0), alu_c, alu_v};
            end
            if (load_mul) begin
                mcand_reg  <= SrcA;
                mplier_reg <= SrcB;
                acc_reg    <= '0;
                count_reg  <= '0;
            end
            if (mul_step) begin
                acc_reg    <= mul_sum;
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_reg >> 1;
                // Counter holds at WIDTH-1 on the final step rather than wrapping.
                if (!mul_last) count_reg <= count_reg + 1'b1;
            end
            if (mul_last) begin
                result_reg <= mul_sum;
                flag_reg   <= {mul_sum[WIDTH-1], (mul_sum == '0), 2'b00};
            end
        end
    end

    assign ALUResult = result_reg;
    assign ALUFlag   = flag_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq at WIDTH=32.
module tb_alu_seq;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [2:0]  ALUControl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic [3:0]  ALUFlag;

    int tests;
    int errors;

    alu_seq #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ALUControl (ALUControl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .ALUFlag    (ALUFlag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one request, scrambles inputs after acceptance, waits for the
    // result, completes the result handshake. cyc counts edges from the
    // acceptance edge (inclusive) to out_valid.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic [3:0] flg, output int cyc,
                         output bit busy_ready, output bit ready_after);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        ALUControl = op; SrcA = a; SrcB = b; in_valid = 1'b1;
        cyc = 0;
        busy_ready = 1'b0;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                in_valid = 1'b0; SrcA = 32'hFFFF_FFFF; SrcB = 32'hFFFF_FFFF; ALUControl = 3'b000;
            end
            if (!out_valid && in_ready) busy_ready = 1'b1;
        end while (!out_valid && cyc < 200);
        res = ALUResult;
        flg = ALUFlag;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        ready_after = in_ready;
        $display("[TB] op=%b a=%h b=%h -> res=%h flags=%b cycles=%0d", op, a, b, res, flg, cyc);
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        SrcA = '0; SrcB = '0; ALUControl = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        tests++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        tests++; if (ALUResult !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", ALUResult); end
        tests++; if (ALUFlag !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", ALUFlag); end
    endtask

    task automatic test_arith();
        logic [31:0] r; logic [3:0] f; int c; bit br, ra;
        logic [2:0]  op_t [5] = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b000};
        logic [31:0] a_t  [5] = '{32'h4, 32'h4, 32'h5, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] b_t  [5] = '{32'h5, 32'h5, 32'h5, 32'h1, 32'h1};
        logic [31:0] er_t [5] = '{32'h9, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h0};
        logic [3:0]  ef_t [5] = '{4'b0000, 4'b1000, 4'b0110, 4'b1001, 4'b0110};
        for (int i = 0; i < 5; i++) begin
            issue(op_t[i], a_t[i], b_t[i], r, f, c, br, ra);
            tests++; if (r !== er_t[i]) begin errors++; $display("FAIL arith%0d_result got=%h exp=%h", i, r, er_t[i]); end
            tests++; if (f !== ef_t[i]) begin errors++; $display("FAIL arith%0d_flags got=%b exp=%b", i, f, ef_t[i]); end
            tests++; if (c !== 1) begin errors++; $display("FAIL arith%0d_latency got=%0d exp=1", i, c); end
            tests++; if (ra !== 1'b1) begin errors++; $display("FAIL arith%0d_ready_after got=%b exp=1", i, ra); end
        end
    endtask

    task automatic test_logic_shift();
        logic [31:0] r; logic [3:0] f; int c; bit br, ra;
        logic [2:0]  op_t [6] = '{3'b010, 3'b100, 3'b101, 3'b110, 3'b101, 3'b101};
        logic [31:0] a_t  [6] = '{32'hF0F0_F0F0, 32'hFFFF_0000, 32'h1, 32'h3, 32'h5, 32'h8000_0001};
        logic [31:0] b_t  [6] = '{32'h0FF0_0FF0, 32'hFFFF_FFFF, 32'd31, 32'h1, 32'h0, 32'h21};
        logic [31:0] er_t [6] = '{32'h00F0_00F0, 32'h0000_FFFF, 32'h8000_0000, 32'h1, 32'h5, 32'h2};
        logic [3:0]  ef_t [6] = '{4'b0000, 4'b0000, 4'b1000, 4'b0010, 4'b0000, 4'b0010};
        for (int i = 0; i < 6; i++) begin
            issue(op_t[i], a_t[i], b_t[i], r, f, c, br, ra);
            tests++; if (r !== er_t[i]) begin errors++; $display("FAIL logic%0d_result got=%h exp=%h", i, r, er_t[i]); end
            tests++; if (f !== ef_t[i]) begin errors++; $display("FAIL logic%0d_flags got=%b exp=%b", i, f, ef_t[i]); end
            tests++; if (c !== 1) begin errors++; $display("FAIL logic%0d_latency got=%0d exp=1", i, c); end
        end
    endtask

    task automatic test_mul();
        logic [31:0] r; logic [3:0] f; int c; bit br, ra;
        issue(3'b111, 32'h1234, 32'h10, r, f, c, br, ra);
        tests++; if (r !== 32'h0001_2340) begin errors++; $display("FAIL mul1_result got=%h exp=00012340", r); end
        tests++; if (f !== 4'b0000) begin errors++; $display("FAIL mul1_flags got=%b exp=0000", f); end
        tests++; if (c !== 33) begin errors++; $display("FAIL mul1_latency got=%0d exp=33", c); end
        tests++; if (br !== 1'b0) begin errors++; $display("FAIL mul1_ready_while_busy got=%b exp=0", br); end
        tests++; if (ra !== 1'b1) begin errors++; $display("FAIL mul1_ready_after got=%b exp=1", ra); end
        issue(3'b111, 32'h1_0000, 32'h1_0000, r, f, c, br, ra);
        tests++; if (r !== 32'h0) begin errors++; $display("FAIL mul2_result got=%h exp=00000000", r); end
        tests++; if (f !== 4'b0100) begin errors++; $display("FAIL mul2_flags got=%b exp=0100", f); end
        issue(3'b111, 32'hFFFF_FFFF, 32'h3, r, f, c, br, ra);
        tests++; if (r !== 32'hFFFF_FFFD) begin errors++; $display("FAIL mul3_result got=%h exp=fffffffd", r); end
        tests++; if (f !== 4'b1000) begin errors++; $display("FAIL mul3_flags got=%b exp=1000", f); end
    endtask

    task automatic test_backpressure();
        ALUControl = 3'b000; SrcA = 32'h4; SrcB = 32'h5; in_valid = 1'b1;
        @(posedge clk); #1;
        // Hold a different request on the inputs while the result waits.
        ALUControl = 3'b001; SrcA = 32'h5; SrcB = 32'h5;
        tests++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_first_valid got=%b exp=1", out_valid); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || ALUResult !== 32'h9 || ALUFlag !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%b rdy=%b r=%h f=%b exp v=1 rdy=0 r=00000009 f=0000",
                         i, out_valid, in_ready, ALUResult, ALUFlag);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || ALUResult !== 32'h0 || ALUFlag !== 4'b0110) begin
            errors++; $display("FAIL bp_held_req got v=%b r=%h f=%b exp v=1 r=00000000 f=0110", out_valid, ALUResult, ALUFlag);
        end
        $display("[TB] backpressure: held SUB 5-5 -> res=%h flags=%b", ALUResult, ALUFlag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_mul();
        logic [31:0] r; logic [3:0] f; int c; bit br, ra;
        issue(3'b000, 32'h4, 32'h5, r, f, c, br, ra);
        ALUControl = 3'b111; SrcA = 32'h1234; SrcB = 32'h10; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        tests++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_mul_busy got=%b exp=0", in_ready); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        tests++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready got=%b exp=1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid got=%b exp=0", out_valid); end
        tests++; if (ALUResult !== 32'h0) begin errors++; $display("FAIL mid_rst_result got=%h exp=0", ALUResult); end
        tests++; if (ALUFlag !== 4'b0000) begin errors++; $display("FAIL mid_rst_flags got=%b exp=0000", ALUFlag); end
        issue(3'b000, 32'h2, 32'h3, r, f, c, br, ra);
        tests++; if (r !== 32'h5) begin errors++; $display("FAIL post_rst_add got=%h exp=00000005", r); end
        tests++; if (c !== 1) begin errors++; $display("FAIL post_rst_latency got=%0d exp=1", c); end
    endtask

    initial begin
        tests = 0;
        errors = 0;
        test_reset();
        test_arith();
        test_logic_shift();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the single-cycle datapath ALU. It widens the op set from 4 to 8 operations (adds XOR, shifts and an iterative multiply), makes the data width a parameter, and registers results and NZCV flags behind a valid/ready handshake on both sides. It sits between the decode/register-read stage and writeback, so a multi-cycle multiply can stall the core cleanly.

## Interface
- WIDTH, 32, datapath width; power of two, ≥ 8.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- SrcA  in  WIDTH  operand A.
- SrcB  in  WIDTH  operand B; for shifts only SrcB[SHW-1:0] is used.
- ALUControl  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 LSL, 110 LSR, 111 MUL.
- out_valid  out  1  ALUResult/ALUFlag are valid.
- out_ready  in  1  consumer accepts the result.
- ALUResult  out  WIDTH  registered result.
- ALUFlag  out  4  registered flags: [3]=N, [2]=Z, [1]=C, [0]=V.

## Operation
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: MUL in progress; in_ready=0, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Acceptance is in_valid & in_ready. SrcA, SrcB and ALUControl are captured at acceptance; later input changes are ignored.
- IDLE, accept, op ≠ MUL: compute the result and flags into output registers, go to HOLD.
- IDLE, accept, op = MUL: load multiplicand, multiplier and accumulator, set the cycle counter to 0, go to BUSY.
- BUSY: radix-2 shift-add, one multiplier bit per cycle. After WIDTH iterations (counter = WIDTH-1) write the low WIDTH product bits and flags, go to HOLD.
- HOLD, out_ready=1: go to IDLE. HOLD, out_ready=0: hold ALUResult, ALUFlag and out_valid stable.
- in_valid outside IDLE is not consumed; the requester must hold it until in_ready.
- Arithmetic:
  - ADD: {C, R} = A + B (WIDTH+1 bits). V = (A[MSB] == B[MSB]) & (R[MSB] ≠ A[MSB]).
  - SUB: {C, R} = A + ~B + 1, so C=1 means no borrow. V = (A[MSB] ≠ B[MSB]) & (R[MSB] ≠ A[MSB]).
  - AND/OR/XOR: C=0, V=0.
  - LSL/LSR: shift by s = SrcB[SHW-1:0]. C = last bit shifted out (LSL: A[WIDTH-s]; LSR: A[s-1]); C=0 when s=0. V=0.
  - MUL: unsigned, low WIDTH bits kept. C=0, V=0.
  - All ops: N = R[MSB], Z = (R == 0).

## Timing
- Reset (any state, including mid-MUL) goes to IDLE next edge. Outputs after reset: in_ready=1, out_valid=0, ALUResult=0, ALUFlag=0. Counter and operand registers are cleared, and any in-flight op is discarded.
- Non-MUL latency: accept at edge k, out_valid=1 after edge k+1.
- MUL latency: accept at edge k, out_valid=1 after edge k+WIDTH+1 (33 cycles for WIDTH=32).
- Result handshake at edge j gives in_ready=1 after edge j. There is no same-cycle turnaround, so peak throughput is one non-MUL op per 2 cycles.
- in_valid and out_ready may both be asserted with no coupling between them. in_ready never depends combinationally on out_ready.
- Counter is $clog2(WIDTH) bits and must not wrap before the last iteration completes.

## Test plan
- WIDTH=32, ADD 4+5 → ALUResult=0x9, ALUFlag=0000, out_valid exactly 1 cycle after accept. SUB 4−5 → 0xFFFFFFFF, flags 1000. SUB 5−5 → 0x0, flags 0110.
- ADD 0x7FFFFFFF+0x1 → 0x80000000, flags 1001. ADD 0xFFFFFFFF+0x1 → 0x0, flags 0110. AND 0xF0F0F0F0 & 0x0FF00FF0 → 0x00F000F0. XOR 0xFFFF0000 ^ 0xFFFFFFFF → 0x0000FFFF, flags 0000.
- LSL 0x1 by 31 → 0x80000000, flags 1000. LSR 0x3 by 1 → 0x1, flags 0010. LSL 0x5 by 0 → 0x5, C=0. LSL with SrcB=0x21 shifts by 1 (upper bits ignored).
- MUL 0x1234 × 0x10 → 0x12340, out_valid exactly 33 cycles after accept, in_ready=0 throughout. MUL 0x10000 × 0x10000 → 0x0, flags 0100.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD → ALUResult/ALUFlag stable, in_ready=0, a held in_valid not consumed. Raise out_ready → in_ready=1 next cycle, then the held request is accepted.
- Assert reset at cycle 10 of a MUL → next cycle in_ready=1, out_valid=0, ALUResult=0, ALUFlag=0. A following ADD 2+3 returns 0x5.
